// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, flag bit positions and the response payload.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned FLAG_W = 4;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [FLAG_W-1:0] flags;
    logic              err;
  } alu_rsp_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arb_slot.sv
// One response slot: captures an ALU response on load, holds it until drained.
module alu_arb_slot
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  alu_rsp_t         rsp_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid,
  output alu_rsp_t         rsp,
  output logic [TAG_W-1:0] tag,
  output logic             free_c
);

  // Free when empty or being emptied this cycle, so drain and refill can overlap.
  assign free_c = ~valid | drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      rsp   <= '0;
      tag   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      rsp   <= rsp_in;
      tag   <= tag_in;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU and registers
// each result into a per-requester response slot. Optional counters: ALU_ARB_PERF_CNT_EN.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic [DATA_W-1:0] r0_req_a,
  input  logic [DATA_W-1:0] r0_req_b,
  input  logic [OP_W-1:0]   r0_req_op,
  input  logic [TAG_W-1:0]  r0_req_tag,
  output logic              r0_resp_valid,
  input  logic              r0_resp_ready,
  output logic [DATA_W-1:0] r0_resp_result,
  output logic [FLAG_W-1:0] r0_resp_flags,
  output logic [TAG_W-1:0]  r0_resp_tag,
  output logic              r0_resp_err,
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic [DATA_W-1:0] r1_req_a,
  input  logic [DATA_W-1:0] r1_req_b,
  input  logic [OP_W-1:0]   r1_req_op,
  input  logic [TAG_W-1:0]  r1_req_tag,
  output logic              r1_resp_valid,
  input  logic              r1_resp_ready,
  output logic [DATA_W-1:0] r1_resp_result,
  output logic [FLAG_W-1:0] r1_resp_flags,
  output logic [TAG_W-1:0]  r1_resp_tag,
  output logic              r1_resp_err,
`ifdef ALU_ARB_PERF_CNT_EN
  output logic [15:0]       r0_grant_cnt,
  output logic [15:0]       r1_grant_cnt,
  output logic [15:0]       stall_cnt,
`endif
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flags
);

  localparam bit FIXED_PRI = (ARB_MODE == 1);

  logic             free0_c, free1_c;
  logic             elig0, elig1;
  logic             gnt0, gnt1;
  logic             rr_last;
  logic [TAG_W-1:0] tag_mux;
  alu_rsp_t         rsp_in, rsp0, rsp1;

  // No handshake completes while reset is asserted.
  assign elig0 = ~rst & r0_req_valid & free0_c;
  assign elig1 = ~rst & r1_req_valid & free1_c;

  // Contention: fixed priority picks port 0, round-robin picks the port not served last.
  assign gnt0 = elig0 & (~elig1 | FIXED_PRI | rr_last);
  assign gnt1 = elig1 & ~gnt0;

  assign r0_req_ready = gnt0;
  assign r1_req_ready = gnt1;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    tag_mux  = '0;
    if (gnt0) begin
      alu_a    = r0_req_a;
      alu_b    = r0_req_b;
      alu_ctrl = r0_req_op;
      tag_mux  = r0_req_tag;
    end else if (gnt1) begin
      alu_a    = r1_req_a;
      alu_b    = r1_req_b;
      alu_ctrl = r1_req_op;
      tag_mux  = r1_req_tag;
    end
  end

  assign rsp_in = '{result: alu_result, flags: alu_flags, err: ~op_legal(alu_ctrl)};

  // rr_last = 1 means port 1 was served last, so port 0 is favoured next.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= 1'b1;
    end else if (gnt0 || gnt1) begin
      rr_last <= gnt1;
    end
  end

  alu_arb_slot #(.TAG_W(TAG_W)) u_slot0 (
    .clk    (clk),
    .rst    (rst),
    .load   (gnt0),
    .drain  (r0_resp_ready),
    .rsp_in (rsp_in),
    .tag_in (tag_mux),
    .valid  (r0_resp_valid),
    .rsp    (rsp0),
    .tag    (r0_resp_tag),
    .free_c (free0_c)
  );

  alu_arb_slot #(.TAG_W(TAG_W)) u_slot1 (
    .clk    (clk),
    .rst    (rst),
    .load   (gnt1),
    .drain  (r1_resp_ready),
    .rsp_in (rsp_in),
    .tag_in (tag_mux),
    .valid  (r1_resp_valid),
    .rsp    (rsp1),
    .tag    (r1_resp_tag),
    .free_c (free1_c)
  );

  assign r0_resp_result = rsp0.result;
  assign r0_resp_flags  = rsp0.flags;
  assign r0_resp_err    = rsp0.err;
  assign r1_resp_result = rsp1.result;
  assign r1_resp_flags  = rsp1.flags;
  assign r1_resp_err    = rsp1.err;

`ifdef ALU_ARB_PERF_CNT_EN
  logic stall_c;
  assign stall_c = (r0_req_valid & ~gnt0) | (r1_req_valid & ~gnt1);

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r0_grant_cnt <= '0;
      r1_grant_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (gnt0 && r0_grant_cnt != 16'hFFFF) r0_grant_cnt <= r0_grant_cnt + 16'd1;
      if (gnt1 && r1_grant_cnt != 16'hFFFF) r1_grant_cnt <= r1_grant_cnt + 16'd1;
      if (stall_c && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
